// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: widths, FSM states and branch-type decode.
// Imported by the interface, the top and the target calculator.
package branch_resolve_unit_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned PC_INC     = 4;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } bru_state_e;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_COND,
        BR_JAL,
        BR_JALR
    } br_type_e;

    // Multiple flags at once are illegal; resolve them as jalr > jal > branch.
    function automatic br_type_e br_decode(input logic is_branch,
                                           input logic is_jal,
                                           input logic is_jalr);
        if (is_jalr) return BR_JALR;
        if (is_jal) return BR_JAL;
        if (is_branch) return BR_COND;
        return BR_NONE;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage decode inputs, fetch redirect handshake and status outputs of the branch resolve unit.
// The unit attaches through the slave modport; the pipeline/fetch side uses master.
interface branch_resolve_unit_if
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = 32
);
    logic              ex_valid;
    logic              ex_is_branch;
    logic              ex_is_jal;
    logic              ex_is_jalr;
    logic [DATA_W-1:0] ex_pc;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_rs1;
    logic              alu_zero;
    logic              redirect_ready;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              squash;
    logic              ex_stall;
    logic              link_valid;
    logic [DATA_W-1:0] link_data;
    logic              exc_valid;
    logic [DATA_W-1:0] exc_pc;
    logic [CNT_W-1:0]  br_count;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
        output ex_pc, ex_imm, ex_rs1, alu_zero, redirect_ready,
        input  redirect_valid, redirect_pc, squash, ex_stall,
        input  link_valid, link_data, exc_valid, exc_pc, br_count, taken_count
    );

    modport slave (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
        input  ex_pc, ex_imm, ex_rs1, alu_zero, redirect_ready,
        output redirect_valid, redirect_pc, squash, ex_stall,
        output link_valid, link_data, exc_valid, exc_pc, br_count, taken_count
    );

endinterface

// File: rtl/branch_resolve_unit_brt_target_calc.sv
// Combinational control-flow target, link value and misalignment flag.
// Kept free of state so a future predictor can reuse it.
module brt_target_calc
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  br_type_e          br_type_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [DATA_W-1:0] rs1_i,
    output logic [DATA_W-1:0] target_o,
    output logic [DATA_W-1:0] link_o,
    output logic              misaligned_o
);

    always_comb begin
        target_o = pc_i + imm_i;
        if (br_type_i == BR_JALR) begin
            target_o    = rs1_i + imm_i;
            target_o[0] = 1'b0;
        end
        link_o       = pc_i + DATA_W'(PC_INC);
        // Bit 0 is always clear here, so bit 1 alone marks a non-word-aligned target.
        misaligned_o = target_o[1];
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in EX, issues a registered redirect to fetch and squashes
// wrong-path instructions for FLUSH_CYCLES cycles afterwards (static not-taken front end).
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    branch_resolve_unit_if.slave bru_if
);

    localparam int unsigned    FCW       = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [FCW-1:0] FC_INIT   = FCW'(FLUSH_CYCLES);
    localparam bit             HAS_FLUSH = (FLUSH_CYCLES != 0);

    bru_state_e        state_q;
    logic [FCW-1:0]    flush_cnt_q;
    logic              redirect_valid_q;
    logic [DATA_W-1:0] redirect_pc_q;
    logic              squash_q;
    logic              ex_stall_q;
    logic              link_valid_q;
    logic [DATA_W-1:0] link_data_q;
    logic              exc_valid_q;
    logic [DATA_W-1:0] exc_pc_q;
    logic [CNT_W-1:0]  br_count_q;
    logic [CNT_W-1:0]  br_count_d;
    logic [CNT_W-1:0]  taken_count_q;
    logic [CNT_W-1:0]  taken_count_d;

    br_type_e          br_type;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] link;
    logic              misaligned;
    logic              take;
    logic              is_link;
    logic              accept;
    logic              handshake;

    assign br_type = br_decode(bru_if.ex_is_branch, bru_if.ex_is_jal, bru_if.ex_is_jalr);

    brt_target_calc #(
        .DATA_W(DATA_W)
    ) u_target_calc (
        .br_type_i   (br_type),
        .pc_i        (bru_if.ex_pc),
        .imm_i       (bru_if.ex_imm),
        .rs1_i       (bru_if.ex_rs1),
        .target_o    (target),
        .link_o      (link),
        .misaligned_o(misaligned)
    );

    always_comb begin
        take    = 1'b0;
        is_link = 1'b0;
        case (br_type)
            BR_JAL, BR_JALR: begin
                take    = 1'b1;
                is_link = 1'b1;
            end
            BR_COND: take = bru_if.alu_zero;
            default: take = 1'b0;
        endcase
        accept    = (state_q == IDLE) && bru_if.ex_valid;
        handshake = (state_q == REDIRECT) && bru_if.redirect_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            flush_cnt_q      <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            squash_q         <= 1'b0;
            ex_stall_q       <= 1'b0;
            link_valid_q     <= 1'b0;
            link_data_q      <= '0;
            exc_valid_q      <= 1'b0;
            exc_pc_q         <= '0;
        end else begin
            link_valid_q <= 1'b0;
            link_data_q  <= '0;
            exc_valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_link) begin
                            link_valid_q <= 1'b1;
                            link_data_q  <= link;
                        end
                        if (take && !misaligned) begin
                            redirect_pc_q    <= target;
                            redirect_valid_q <= 1'b1;
                            squash_q         <= 1'b1;
                            ex_stall_q       <= 1'b1;
                            state_q          <= REDIRECT;
                        end else if (take) begin
                            // Misaligned target: trap instead of redirecting, still flush wrong path.
                            exc_valid_q <= 1'b1;
                            exc_pc_q    <= bru_if.ex_pc;
                            if (HAS_FLUSH) begin
                                squash_q    <= 1'b1;
                                flush_cnt_q <= FC_INIT;
                                state_q     <= FLUSH;
                            end
                        end
                    end
                end
                REDIRECT: begin
                    if (handshake) begin
                        redirect_valid_q <= 1'b0;
                        ex_stall_q       <= 1'b0;
                        if (HAS_FLUSH) begin
                            flush_cnt_q <= FC_INIT;
                            state_q     <= FLUSH;
                        end else begin
                            squash_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    flush_cnt_q <= flush_cnt_q - FCW'(1);
                    if (flush_cnt_q == FCW'(1)) begin
                        squash_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Statistics saturate at all-ones instead of wrapping.
    always_comb begin
        br_count_d    = br_count_q;
        taken_count_d = taken_count_q;
        if (accept && bru_if.ex_is_branch && (br_count_q != '1))
            br_count_d = br_count_q + CNT_W'(1);
        if (handshake && (taken_count_q != '1))
            taken_count_d = taken_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count_q    <= '0;
            taken_count_q <= '0;
        end else begin
            br_count_q    <= br_count_d;
            taken_count_q <= taken_count_d;
        end
    end

    assign bru_if.redirect_valid = redirect_valid_q;
    assign bru_if.redirect_pc    = redirect_pc_q;
    assign bru_if.squash         = squash_q;
    assign bru_if.ex_stall       = ex_stall_q;
    assign bru_if.link_valid     = link_valid_q;
    assign bru_if.link_data      = link_data_q;
    assign bru_if.exc_valid      = exc_valid_q;
    assign bru_if.exc_pc         = exc_pc_q;
    assign bru_if.br_count       = br_count_q;
    assign bru_if.taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: default instance (FLUSH_CYCLES=2, CNT_W=32) and a
// second instance (FLUSH_CYCLES=0, CNT_W=4) for the no-flush and saturation corners.
module tb_branch_resolve_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    branch_resolve_unit_if #(.DATA_W(64), .CNT_W(32)) b1 ();
    branch_resolve_unit_if #(.DATA_W(64), .CNT_W(4))  b2 ();

    branch_resolve_unit #(.DATA_W(64), .FLUSH_CYCLES(2), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .bru_if(b1.slave));
    branch_resolve_unit #(.DATA_W(64), .FLUSH_CYCLES(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .bru_if(b2.slave));

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        b1.ex_valid = 0; b1.ex_is_branch = 0; b1.ex_is_jal = 0; b1.ex_is_jalr = 0;
        b1.ex_pc = '0; b1.ex_imm = '0; b1.ex_rs1 = '0; b1.alu_zero = 0; b1.redirect_ready = 0;
        b2.ex_valid = 0; b2.ex_is_branch = 0; b2.ex_is_jal = 0; b2.ex_is_jalr = 0;
        b2.ex_pc = '0; b2.ex_imm = '0; b2.ex_rs1 = '0; b2.alu_zero = 0; b2.redirect_ready = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        #2 rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        #2 rst_n = 0;
        #2;
        checks++;
        if ({b1.redirect_valid, b1.squash, b1.ex_stall, b1.link_valid, b1.exc_valid} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000",
                {b1.redirect_valid, b1.squash, b1.ex_stall, b1.link_valid, b1.exc_valid});
        end
        checks++;
        if ((b1.redirect_pc | b1.link_data | b1.exc_pc) !== 64'h0) begin
            failures++; $display("FAIL reset_data got=%0h exp=0", b1.redirect_pc | b1.link_data | b1.exc_pc);
        end
        checks++;
        if ({b1.br_count, b1.taken_count, b2.br_count, b2.taken_count} !== 72'h0) begin
            failures++; $display("FAIL reset_counts got=%0h/%0h exp=0/0", b1.br_count, b1.taken_count);
        end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_beq_taken;
        do_reset();
        b1.ex_valid = 1; b1.ex_is_branch = 1; b1.alu_zero = 1;
        b1.ex_pc = 64'h100; b1.ex_imm = 64'h20; b1.redirect_ready = 1;
        tick();
        b1.ex_valid = 0; b1.ex_is_branch = 0;
        checks++;
        if ({b1.redirect_valid, b1.squash, b1.ex_stall} !== 3'b111) begin
            failures++; $display("FAIL beq_redirect_flags got=%b exp=111", {b1.redirect_valid, b1.squash, b1.ex_stall});
        end
        checks++;
        if (b1.redirect_pc !== 64'h120) begin
            failures++; $display("FAIL beq_redirect_pc got=%0h exp=120", b1.redirect_pc);
        end
        tick();
        checks++;
        if ({b1.redirect_valid, b1.squash, b1.ex_stall} !== 3'b010) begin
            failures++; $display("FAIL beq_flush1 got=%b exp=010", {b1.redirect_valid, b1.squash, b1.ex_stall});
        end
        checks++;
        if (b1.taken_count !== 32'd1 || b1.br_count !== 32'd1) begin
            failures++; $display("FAIL beq_counts got=%0d/%0d exp=1/1", b1.taken_count, b1.br_count);
        end
        tick();
        checks++;
        if (b1.squash !== 1'b1) begin
            failures++; $display("FAIL beq_flush2 got=%b exp=1", b1.squash);
        end
        tick();
        checks++;
        if ({b1.redirect_valid, b1.squash, b1.ex_stall} !== 3'b000) begin
            failures++; $display("FAIL beq_idle got=%b exp=000", {b1.redirect_valid, b1.squash, b1.ex_stall});
        end
    endtask

    task automatic test_bne_not_taken;
        do_reset();
        b1.ex_valid = 1; b1.ex_is_branch = 1; b1.alu_zero = 0;
        b1.ex_pc = 64'h300; b1.ex_imm = 64'h40; b1.redirect_ready = 1;
        tick();
        b1.ex_valid = 0; b1.ex_is_branch = 0;
        checks++;
        if ({b1.redirect_valid, b1.squash, b1.ex_stall, b1.link_valid} !== 4'b0000) begin
            failures++; $display("FAIL bne_flags got=%b exp=0000", {b1.redirect_valid, b1.squash, b1.ex_stall, b1.link_valid});
        end
        checks++;
        if (b1.br_count !== 32'd1 || b1.taken_count !== 32'd0) begin
            failures++; $display("FAIL bne_counts got=%0d/%0d exp=1/0", b1.br_count, b1.taken_count);
        end
        tick();
        checks++;
        if (b1.squash !== 1'b0) begin
            failures++; $display("FAIL bne_squash_after got=%b exp=0", b1.squash);
        end
    endtask

    task automatic test_jalr_stall;
        do_reset();
        b1.ex_valid = 1; b1.ex_is_jalr = 1; b1.ex_pc = 64'h400;
        b1.ex_rs1 = 64'h2001; b1.ex_imm = 64'h10; b1.redirect_ready = 0;
        tick();
        // Wrong-path contents presented while stalled must be ignored.
        b1.ex_is_jalr = 0; b1.ex_is_branch = 1; b1.alu_zero = 1;
        b1.ex_pc = 64'h999000; b1.ex_imm = 64'h8;
        checks++;
        if ({b1.redirect_valid, b1.ex_stall, b1.squash} !== 3'b111 || b1.redirect_pc !== 64'h2010) begin
            failures++; $display("FAIL jalr_redirect got=%b pc=%0h exp=111 pc=2010",
                {b1.redirect_valid, b1.ex_stall, b1.squash}, b1.redirect_pc);
        end
        checks++;
        if (b1.link_valid !== 1'b1 || b1.link_data !== 64'h404) begin
            failures++; $display("FAIL jalr_link got=%b/%0h exp=1/404", b1.link_valid, b1.link_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (b1.ex_stall !== 1'b1 || b1.redirect_valid !== 1'b1 || b1.redirect_pc !== 64'h2010 || b1.link_valid !== 1'b0) begin
                failures++; $display("FAIL jalr_hold%0d got=stall %b rv %b pc %0h link %b exp=1 1 2010 0",
                    i, b1.ex_stall, b1.redirect_valid, b1.redirect_pc, b1.link_valid);
            end
            if (i == 2) b1.redirect_ready = 1;
        end
        tick();
        b1.ex_valid = 0; b1.ex_is_branch = 0;
        checks++;
        if ({b1.redirect_valid, b1.ex_stall, b1.squash, b1.link_valid} !== 4'b0010) begin
            failures++; $display("FAIL jalr_post_hs got=%b exp=0010", {b1.redirect_valid, b1.ex_stall, b1.squash, b1.link_valid});
        end
        checks++;
        if (b1.taken_count !== 32'd1 || b1.br_count !== 32'd0) begin
            failures++; $display("FAIL jalr_counts got=%0d/%0d exp=1/0", b1.taken_count, b1.br_count);
        end
        tick();
        tick();
        checks++;
        if (b1.squash !== 1'b0 || b1.redirect_valid !== 1'b0) begin
            failures++; $display("FAIL jalr_idle got=%b%b exp=00", b1.squash, b1.redirect_valid);
        end
    endtask

    task automatic test_jal_misaligned;
        do_reset();
        b1.ex_valid = 1; b1.ex_is_jal = 1; b1.ex_pc = 64'h200; b1.ex_imm = 64'h6; b1.redirect_ready = 1;
        tick();
        b1.ex_valid = 0; b1.ex_is_jal = 0;
        checks++;
        if ({b1.exc_valid, b1.redirect_valid, b1.squash, b1.link_valid} !== 4'b1011 || b1.exc_pc !== 64'h200) begin
            failures++; $display("FAIL jal_exc got=%b pc=%0h exp=1011 pc=200",
                {b1.exc_valid, b1.redirect_valid, b1.squash, b1.link_valid}, b1.exc_pc);
        end
        checks++;
        if (b1.link_data !== 64'h204) begin
            failures++; $display("FAIL jal_link got=%0h exp=204", b1.link_data);
        end
        tick();
        checks++;
        if ({b1.exc_valid, b1.redirect_valid, b1.squash} !== 3'b001) begin
            failures++; $display("FAIL jal_flush2 got=%b exp=001", {b1.exc_valid, b1.redirect_valid, b1.squash});
        end
        tick();
        checks++;
        if (b1.squash !== 1'b0 || b1.taken_count !== 32'd0) begin
            failures++; $display("FAIL jal_idle got=%b/%0d exp=0/0", b1.squash, b1.taken_count);
        end
    endtask

    task automatic test_reset_mid_redirect;
        do_reset();
        b1.ex_valid = 1; b1.ex_is_branch = 1; b1.alu_zero = 1;
        b1.ex_pc = 64'h500; b1.ex_imm = 64'h100; b1.redirect_ready = 0;
        tick();
        b1.ex_valid = 0; b1.ex_is_branch = 0;
        checks++;
        if (b1.redirect_valid !== 1'b1) begin
            failures++; $display("FAIL rstmid_pre got=%b exp=1", b1.redirect_valid);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({b1.redirect_valid, b1.squash, b1.ex_stall} !== 3'b000 || b1.redirect_pc !== 64'h0 || b1.br_count !== 32'd0) begin
            failures++; $display("FAIL rstmid_async got=%b pc=%0h br=%0d exp=000 pc=0 br=0",
                {b1.redirect_valid, b1.squash, b1.ex_stall}, b1.redirect_pc, b1.br_count);
        end
        b1.redirect_ready = 1;
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({b1.redirect_valid, b1.squash, b1.ex_stall} !== 3'b000 || b1.taken_count !== 32'd0) begin
                failures++; $display("FAIL rstmid_after%0d got=%b taken=%0d exp=000 taken=0",
                    i, {b1.redirect_valid, b1.squash, b1.ex_stall}, b1.taken_count);
            end
        end
    endtask

    task automatic test_no_flush_saturate;
        do_reset();
        b2.redirect_ready = 1;
        b2.alu_zero = 1;
        b2.ex_imm = 64'h40;
        for (int i = 1; i <= 17; i++) begin
            b2.ex_valid = 1; b2.ex_is_branch = 1; b2.ex_pc = 64'h1000 + 64'(i * 16);
            tick();
            b2.ex_valid = 0; b2.ex_is_branch = 0;
            checks++;
            if ({b2.redirect_valid, b2.squash} !== 2'b11 || b2.redirect_pc !== 64'h1040 + 64'(i * 16)) begin
                failures++; $display("FAIL nf_redirect%0d got=%b pc=%0h exp=11 pc=%0h",
                    i, {b2.redirect_valid, b2.squash}, b2.redirect_pc, 64'h1040 + 64'(i * 16));
            end
            tick();
            checks++;
            if ({b2.redirect_valid, b2.squash} !== 2'b00 || b2.taken_count !== 4'((i > 15) ? 15 : i)) begin
                failures++; $display("FAIL nf_after%0d got=%b taken=%0d exp=00 taken=%0d",
                    i, {b2.redirect_valid, b2.squash}, b2.taken_count, (i > 15) ? 15 : i);
            end
        end
        checks++;
        if (b2.br_count !== 4'hF) begin
            failures++; $display("FAIL nf_br_sat got=%0d exp=15", b2.br_count);
        end
        b2.ex_valid = 1; b2.ex_is_jal = 1; b2.ex_pc = 64'h200; b2.ex_imm = 64'h6;
        tick();
        b2.ex_valid = 0; b2.ex_is_jal = 0;
        checks++;
        if ({b2.exc_valid, b2.squash, b2.redirect_valid} !== 3'b100) begin
            failures++; $display("FAIL nf_misaligned got=%b exp=100", {b2.exc_valid, b2.squash, b2.redirect_valid});
        end
        tick();
        checks++;
        if ({b2.exc_valid, b2.squash} !== 2'b00) begin
            failures++; $display("FAIL nf_misaligned_after got=%b exp=00", {b2.exc_valid, b2.squash});
        end
    endtask

    initial begin
        idle_inputs();
        tick();
        test_reset();
        test_beq_taken();
        test_bne_not_taken();
        test_jalr_stall();
        test_jal_misaligned();
        test_reset_mid_redirect();
        test_no_flush_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumes the ALU compare result (Zero) and branch/jump decode for the instruction in EX.
- Computes the control-flow target and the link value.
- Issues a registered redirect to fetch over a valid/ready handshake, then squashes wrong-path instructions for a fixed number of cycles.
- Static not-taken front end: every taken branch or jump is a redirect.

Parameters:
- DATA_W, 64, datapath/PC width (shared `DATA_W).
- FLUSH_CYCLES, 2, squash cycles after a redirect handshake; 0 legal.
- CNT_W, 32, width of the saturating statistics counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_is_branch  in  1  conditional branch
- ex_is_jal  in  1  JAL
- ex_is_jalr  in  1  JALR
- ex_pc  in  DATA_W  PC of EX instruction
- ex_imm  in  DATA_W  sign-extended immediate
- ex_rs1  in  DATA_W  forwarded rs1 (JALR base)
- alu_zero  in  1  ALU Zero; branch taken iff 1 (BEQ via SUB, BNE/BLT/BGE via inverted compares)
- redirect_ready  in  1  fetch accepts redirect
- redirect_valid  out  1  redirect pending
- redirect_pc  out  DATA_W  new fetch PC
- squash  out  1  kill IF/ID and ID/EX contents
- ex_stall  out  1  hold EX and upstream
- link_valid  out  1  rd write of PC+4 (JAL/JALR)
- link_data  out  DATA_W  ex_pc+4
- exc_valid  out  1  1-cycle misaligned-target exception pulse
- exc_pc  out  DATA_W  PC of faulting instruction
- br_count  out  CNT_W  resolved conditional branches
- taken_count  out  CNT_W  redirects issued

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, counters 0.
  - Takes effect immediately, including mid-redirect or mid-flush; a pending redirect is dropped.
- Target arithmetic, all modulo 2^DATA_W:
  - Branch/JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
  - Link: ex_pc+4.
- Accept rule: EX inputs are sampled only when state==IDLE and ex_valid=1. They are ignored whenever squash=1 or ex_stall=1.
- take = ex_is_jal | ex_is_jalr | (ex_is_branch & alu_zero). More than one type flag set at once is illegal; priority is jalr > jal > branch.
- Latency: all outputs are registered. Accept at edge N; outputs are visible in cycle N+1.
- IDLE:
  - Accepted take with target bit1=0: redirect_pc<=target, redirect_valid<=1 -> REDIRECT.
  - Accepted take with target bit1=1: no redirect; exc_valid pulse, exc_pc<=ex_pc -> FLUSH (or IDLE if FLUSH_CYCLES=0).
  - Not taken: stay in IDLE.
  - link_valid/link_data pulse for 1 cycle for any accepted JAL/JALR, including the misaligned case.
- REDIRECT:
  - redirect_valid=1, squash=1, ex_stall=1.
  - redirect_pc is stable until the handshake.
  - Handshake on redirect_valid & redirect_ready at a rising edge, including the first REDIRECT cycle. After it: redirect_valid<=0; go to FLUSH with counter=FLUSH_CYCLES, or to IDLE if FLUSH_CYCLES=0.
- FLUSH:
  - squash=1, ex_stall=0.
  - Counter decrements each cycle; IDLE when the counter reaches 1 -> 0. Exactly FLUSH_CYCLES squash cycles after the handshake.
- Counters:
  - br_count +1 per accepted ex_is_branch.
  - taken_count +1 per redirect handshake.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package/def.h: DATA_W, state enum (IDLE, REDIRECT, FLUSH), branch-type encoding, PC increment constant 4.
- Sub-module: brt_target_calc, combinational target/link/misalign computation, reusable by a future predictor.
- FSM, handshake and counters stay in the top.

Test Plan:
1. BEQ, ex_pc=0x100, ex_imm=0x20, alu_zero=1, redirect_ready=1 -> next cycle redirect_valid=1 with redirect_pc=0x120; handshake the same cycle; squash high for 1+2 cycles; taken_count=1, br_count=1.
2. BNE not taken, alu_zero=0 -> no redirect, squash=0, br_count=1, taken_count=0.
3. JALR, ex_rs1=0x2001, ex_imm=0x10, ex_pc=0x400, redirect_ready held 0 for 3 cycles -> redirect_pc=0x2010 stable, ex_stall=1 for 4 cycles, link_data=0x404 pulsed once; EX inputs changed during the stall are ignored.
4. JAL, ex_pc=0x200, ex_imm=0x6 -> target 0x206 misaligned: exc_valid 1-cycle pulse with exc_pc=0x200, no redirect_valid, squash for 2 cycles.
5. Taken branch, rst_n dropped to 0 during REDIRECT -> all outputs 0 immediately, without waiting for a clock edge; after release, state IDLE and the pending redirect is never issued.
6. FLUSH_CYCLES=0, 2^CNT_W+1 taken branches -> squash is asserted only in REDIRECT cycles; taken_count saturates at all-ones.
